// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The result encoding is packed as {lt, eq, gt}.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice; neither flag set means equal.
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             dlt,
    output logic             dgt
);

    assign dlt = (x < y);
    assign dgt = (x > y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator: DIGIT bits per cycle, stops at the first differing digit.
// Handshake: start is taken only on an edge where ready=1; done pulses for one cycle and lt/eq/gt stay valid until the next accepted start.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [1:0]       fsm_state
);
    import serial_cmp_pkg::*;

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       res;
    logic             dlt;
    logic             dgt;
    logic             last_digit;
    logic [WIDTH-1:0] msb_flip;

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .x   (sa[WIDTH-1 -: DIGIT]),
        .y   (sb[WIDTH-1 -: DIGIT]),
        .dlt (dlt),
        .dgt (dgt)
    );

    assign last_digit = (cnt == CNT_W'(N - 1));
    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign msb_flip   = WIDTH'(signed_mode) << (WIDTH - 1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (dlt || dgt || last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            res <= RES_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a ^ msb_flip;
                        sb  <= b ^ msb_flip;
                        cnt <= '0;
                        res <= RES_NONE;
                    end
                end
                RUN: begin
                    if (dlt) begin
                        res <= RES_LT;
                    end else if (dgt) begin
                        res <= RES_GT;
                    end else if (last_digit) begin
                        res <= RES_EQ;
                    end else begin
                        sa  <= sa << DIGIT;
                        sb  <= sb << DIGIT;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready        = (state == IDLE);
    assign done         = (state == DONE);
    assign {lt, eq, gt} = res;
    assign fsm_state    = state;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: a WIDTH=8/DIGIT=2 instance driven from a vector table
// plus hand sequences, and a WIDTH=8/DIGIT=1 instance driven with back-to-back random operations.
module tb_serial_magnitude_comparator;
    import serial_cmp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start2 = 1'b0;
    logic       start1 = 1'b0;
    logic       sm = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       ready2, done2, lt2, eq2, gt2;
    logic       ready1, done1, lt1, eq1, gt1;
    logic [1:0] st2, st1;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm), .a(a), .b(b),
        .ready(ready2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2), .fsm_state(st2)
    );

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm), .a(a), .b(b),
        .ready(ready1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .fsm_state(st1)
    );

    typedef struct {
        logic       s;
        logic [7:0] av;
        logic [7:0] bv;
        logic [2:0] res;
        int         k;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge with the selected DUT idle; returns the done edge
    // (accept edge = 0) or -1 on timeout, and leaves the DUT idle again.
    task automatic run_op(input bit d1, input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input bit poke, output logic [2:0] res, output int edge_n);
        int n;
        bit got;
        sm = s; a = av; b = bv;
        if (d1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        check("ready_fall", d1 ? ready1 : ready2, 1'b0);
        got = 1'b0;
        n = 0;
        res = '0;
        while (!got && n < 20) begin
            if (poke && n == 1) begin
                a = ~av; b = av; sm = ~s;
                if (d1) start1 = 1'b1; else start2 = 1'b1;
            end
            if (poke && n == 2) begin
                start1 = 1'b0; start2 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if ((d1 ? done1 : done2) === 1'b1) begin
                got = 1'b1;
                res = d1 ? {lt1, eq1, gt1} : {lt2, eq2, gt2};
            end
        end
        start1 = 1'b0; start2 = 1'b0;
        check("done_seen", got, 1'b1);
        edge_n = got ? n + 1 : -1;
        @(posedge clk); #1;
        check("ready_return", d1 ? ready1 : ready2, 1'b1);
        check("done_pulse_len", d1 ? done1 : done2, 1'b0);
    endtask

    initial begin
        logic [2:0] r;
        int         e;
        int         k;
        logic [7:0] ra, rb, fa, fb;
        logic       rs;
        logic [2:0] er;
        bit         saw_done;

        vecs[0] = '{1'b0, 8'h5A, 8'h5A, RES_EQ, 4};
        vecs[1] = '{1'b0, 8'hC3, 8'h3C, RES_GT, 1};
        vecs[2] = '{1'b1, 8'hC3, 8'h3C, RES_LT, 1};
        vecs[3] = '{1'b0, 8'h12, 8'h13, RES_LT, 4};
        vecs[4] = '{1'b1, 8'h80, 8'h7F, RES_LT, 1};
        vecs[5] = '{1'b0, 8'h80, 8'h7F, RES_GT, 1};
        vecs[6] = '{1'b1, 8'hFF, 8'hFE, RES_GT, 4};
        vecs[7] = '{1'b0, 8'h00, 8'h00, RES_EQ, 4};
        vecs[8] = '{1'b1, 8'hFF, 8'hFF, RES_EQ, 4};
        vecs[9] = '{1'b0, 8'h34, 8'h38, RES_LT, 3};

        // Clock/reset: reset held for two edges.
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_ready", ready2, 1'b1);
        check("rst_done", done2, 1'b0);
        check("rst_result", {lt2, eq2, gt2}, RES_NONE);
        check("rst_ready_d1", ready1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_result_zero", {lt2, eq2, gt2}, RES_NONE);

        // Table-driven vectors on the DIGIT=2 instance.
        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, vecs[i].s, vecs[i].av, vecs[i].bv, 1'b0, r, e);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_done_edge", i), e, vecs[i].k + 1);
        end

        // Results hold through IDLE.
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", {lt2, eq2, gt2}, RES_LT);

        // Start during RUN must not disturb the latched operands.
        run_op(1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1, r, e);
        check("poke_result", r, RES_EQ);
        check("poke_done_edge", e, 5);

        // Reset on edge 3 of a 4-digit operation, with start also high.
        sm = 1'b0; a = 8'h5A; b = 8'h5A; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_ready", ready2, 1'b1);
        check("midrun_rst_done", done2, 1'b0);
        check("midrun_rst_result", {lt2, eq2, gt2}, RES_NONE);
        @(posedge clk); #1;
        check("rst_beats_start", ready2, 1'b1);
        reset = 1'b0; start2 = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1 || {lt2, eq2, gt2} !== RES_NONE) saw_done = 1'b1;
        end
        check("no_done_after_rst", saw_done, 1'b0);

        // Back-to-back random operations on the DIGIT=1 instance.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 5 == 0) ? ra : 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            fa = ra; fb = rb;
            if (rs) begin
                er = ($signed(fa) < $signed(fb)) ? RES_LT : ($signed(fa) > $signed(fb)) ? RES_GT : RES_EQ;
            end else begin
                er = (fa < fb) ? RES_LT : (fa > fb) ? RES_GT : RES_EQ;
            end
            k = 8;
            for (int j = 7; j >= 0; j--) begin
                if (ra[j] != rb[j] && k == 8) k = 7 - j + 1;
            end
            exp_q.push_back(er);
            run_op(1'b1, rs, ra, rb, 1'b0, r, e);
            check($sformatf("rnd%0d_result", i), r, exp_q.pop_front());
            check($sformatf("rnd%0d_done_edge", i), e, k + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised, MSB-first serial magnitude comparator. It compares two WIDTH-bit operands DIGIT bits per clock and stops at the first differing digit. It has a start/ready/done handshake, a per-operation signed/unsigned mode, and registered lt/eq/gt results that are held until the next operation. It sits beside the datapath wherever area matters more than compare latency.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT, otherwise elaboration fails.
- DIGIT, 2: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT digits.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only on an edge where ready=1.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a, b  in  WIDTH  operands; sampled with start.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- lt, eq, gt  out  1 each  one-hot result; all zero while an operation is pending.

## Operation
- FSM with three states:
  - IDLE: ready=1. On start, latch a and b into shift registers, clear lt/eq/gt, clear the digit counter, go to RUN.
  - RUN: compare the top DIGIT bits of the shift registers.
    - If they differ, register lt/gt from that digit and go to DONE.
    - If they are equal and this is digit N-1, register eq=1 and go to DONE.
    - Otherwise shift both registers left by DIGIT, increment the counter, stay in RUN.
  - DONE: done=1, ready=0; go to IDLE unconditionally.
- Signed mode: at latch, invert the MSB of both operands. The compare is then unsigned on the modified values. No other signed logic is used.
- Digit compare is unsigned on DIGIT bits. Counter width is clog2(N).
- start is ignored in RUN and DONE. It is not queued, and it must not corrupt the latched operands.
- lt/eq/gt hold their last value through IDLE until the next accepted start clears them.
- Exactly one of lt/eq/gt is 1 whenever done=1.
- Reset, including mid-RUN: next state is IDLE. ready=1, done=0, lt=eq=gt=0, counter=0. No done pulse is produced for the aborted operation.
- If reset and start are high on the same edge, reset wins and start is dropped.

## Timing
- Reset values: ready=1, done=0, lt=0, eq=0, gt=0.
- Count the accept edge as edge 0. If k digits are examined (1 ≤ k ≤ N), results are registered and done rises on edge k+1.
- Best case: done on edge 2 (MSB digit differs). Worst case: done on edge N+1 (operands equal or differ only in the last digit).
- ready falls on edge 1 and returns high on the edge after done. Minimum issue interval is k+2 cycles.
- No combinational path from any input to any output. All outputs are registered or decoded from state only.

## Structure
- Package serial_cmp_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a result-encoding localparam (LT=3'b100, EQ=3'b010, GT=3'b001) that both the RTL and the bench use.
- Sub-module cmp_digit, parameter DIGIT: combinational compare of two DIGIT-bit values, outputs dlt and dgt (neither = equal). One instance is used.
- Top level holds the FSM, the shift registers, the counter and the result registers.

## Test plan
All scenarios use WIDTH=8, DIGIT=2 (N=4) unless stated.
- Reset held 2 cycles, then released -> ready=1, done=0, lt=eq=gt=0. Results remain zero until a start is accepted.
- Unsigned, a=0x5A, b=0x5A -> done on edge 5, eq=1. ready falls on edge 1 and returns high on edge 6.
- Unsigned, a=0xC3, b=0x3C -> MSB digit differs, done on edge 2, gt=1.
- Signed, a=0xC3 (-61), b=0x3C (+60) -> done on edge 2, lt=1. Unsigned, a=0x12, b=0x13 -> done on edge 5, lt=1.
- Start pulsed with new operands during RUN, then reset asserted on edge 3 of a 4-digit operation -> the in-RUN start has no effect; after reset ready=1, no done pulse, outputs zero.
- Rebuild with DIGIT=1 and WIDTH=8, run random a, b, signed_mode with back-to-back starts -> each done appears on edge (first differing bit index)+2 and matches a reference compare. eq=1 cases take exactly 9 edges.
